// File: rtl/lane_rotating_dual_port_ram.sv
// Lane-banked dual-port RAM: port A is byte-addressed and rotates across
// entry boundaries, port B is word-aligned; port A wins lane write collisions.
module lane_rotating_dual_port_ram #(
  parameter int laneWidth      = 8,
  parameter int nrOfLanes      = 4,
  parameter int nrOfEntries    = 512,
  parameter int outputRegister = 0
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     requestA,
  input  logic                                     writeEnableA,
  input  logic [$clog2(nrOfEntries*nrOfLanes)-1:0] byteAddressA,
  input  logic [nrOfLanes-1:0]                     byteEnableA,
  input  logic [laneWidth*nrOfLanes-1:0]           dataInA,
  output logic [laneWidth*nrOfLanes-1:0]           dataOutA,
  output logic                                     dataValidA,
  input  logic                                     requestB,
  input  logic                                     writeEnableB,
  input  logic [$clog2(nrOfEntries)-1:0]           addressB,
  input  logic [nrOfLanes-1:0]                     byteEnableB,
  input  logic [laneWidth*nrOfLanes-1:0]           dataInB,
  output logic [laneWidth*nrOfLanes-1:0]           dataOutB,
  output logic                                     dataValidB,
  output logic                                     collisionB
);
  localparam int W  = laneWidth;
  localparam int L  = nrOfLanes;
  localparam int DW = W * L;
  localparam int OW = $clog2(L);
  localparam int EW = $clog2(nrOfEntries);

  typedef logic [OW-1:0] lane_t;
  typedef logic [EW-1:0] entry_t;
  typedef logic [W-1:0]  byte_t;

  logic         req_a, req_b, rd_a, rd_b;
  entry_t       word_a, word_a_nxt;
  lane_t        off_a;
  lane_t        byte_a [L];
  entry_t       addr_a [L];
  byte_t        wdat_a [L];
  byte_t        wdat_b [L];
  byte_t        lane_a [L];
  byte_t        lane_b [L];
  logic [L-1:0] we_a, we_b_req, we_b, coll;

  always_comb begin
    req_a      = requestA & ~reset;
    req_b      = requestB & ~reset;
    rd_a       = req_a & ~writeEnableA;
    rd_b       = req_b & ~writeEnableB;
    word_a     = entry_t'(byteAddressA >> OW);
    off_a      = byteAddressA[OW-1:0];
    word_a_nxt = (word_a == entry_t'(nrOfEntries - 1)) ?
                 '0 : word_a + entry_t'(1);
    // lane j holds data byte (j - off); lanes below off spill to next entry
    for (int j = 0; j < L; j++) begin
      byte_a[j]   = lane_t'(j) - off_a;
      addr_a[j]   = (lane_t'(j) < off_a) ? word_a_nxt : word_a;
      wdat_a[j]   = dataInA[(L-1-int'(byte_a[j]))*W +: W];
      wdat_b[j]   = dataInB[(L-1-j)*W +: W];
      we_a[j]     = req_a & writeEnableA & byteEnableA[byte_a[j]];
      we_b_req[j] = req_b & writeEnableB & byteEnableB[j];
      coll[j]     = we_a[j] & we_b_req[j] & (addr_a[j] == addressB);
      we_b[j]     = we_b_req[j] & ~coll[j];
    end
  end

  for (genvar j = 0; j < L; j++) begin : g_lane
    byte_t bank [nrOfEntries];
    byte_t rd_a_q, rd_b_q;

    always_ff @(posedge clock) begin
      if (we_a[j]) bank[addr_a[j]] <= wdat_a[j];
      if (we_b[j]) bank[addressB] <= wdat_b[j];
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        rd_a_q <= '0;
        rd_b_q <= '0;
      end else begin
        if (rd_a) rd_a_q <= bank[addr_a[j]];
        if (rd_b) rd_b_q <= bank[addressB];
      end
    end

    assign lane_a[j] = rd_a_q;
    assign lane_b[j] = rd_b_q;
  end

  lane_t         off_q, off_d;
  logic          vld_a_q, vld_a_d, vld_b_q, vld_b_d;
  logic          vld2_a_q, vld2_a_d, vld2_b_q, vld2_b_d;
  logic          coll_q, coll_d;
  logic [DW-1:0] rot_a, cat_b;
  logic [DW-1:0] out_a_q, out_a_d, out_b_q, out_b_d;

  always_comb begin
    off_d    = rd_a ? off_a : off_q;
    vld_a_d  = rd_a;
    vld_b_d  = rd_b;
    vld2_a_d = vld_a_q;
    vld2_b_d = vld_b_q;
    coll_d   = |coll;
    rot_a    = '0;
    cat_b    = '0;
    for (int i = 0; i < L; i++) begin
      rot_a[(L-1-i)*W +: W] = lane_a[lane_t'(off_q + lane_t'(i))];
      cat_b[(L-1-i)*W +: W] = lane_b[i];
    end
    out_a_d = vld_a_q ? rot_a : out_a_q;
    out_b_d = vld_b_q ? cat_b : out_b_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      off_q    <= '0;
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      vld2_a_q <= 1'b0;
      vld2_b_q <= 1'b0;
      coll_q   <= 1'b0;
      out_a_q  <= '0;
      out_b_q  <= '0;
    end else begin
      off_q    <= off_d;
      vld_a_q  <= vld_a_d;
      vld_b_q  <= vld_b_d;
      vld2_a_q <= vld2_a_d;
      vld2_b_q <= vld2_b_d;
      coll_q   <= coll_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
    end
  end

  always_comb begin
    dataOutA   = '0;
    dataOutB   = '0;
    dataValidA = 1'b0;
    dataValidB = 1'b0;
    collisionB = 1'b0;
    if (!reset) begin
      dataOutA   = (outputRegister != 0) ? out_a_q : rot_a;
      dataOutB   = (outputRegister != 0) ? out_b_q : cat_b;
      dataValidA = (outputRegister != 0) ? vld2_a_q : vld_a_q;
      dataValidB = (outputRegister != 0) ? vld2_b_q : vld_b_q;
      collisionB = coll_q;
    end
  end
endmodule

// File: doc/lane_rotating_dual_port_ram.md
Name: lane_rotating_dual_port_ram

Overview:
Dual-port, single-clock SRAM built from nrOfLanes independent lane banks, each laneWidth wide. Port A is byte-addressed and supports unaligned word accesses that straddle two entries, with per-lane write enables. Port B is word-aligned with byte enables. Reads are registered with matching valid strobes, and an optional output register stage is available. The block sits between the CPU custom-instruction path (port A) and the DMA engine (port B), and is the generalised successor of the fixed 4-lane offset RAM.

Parameters:
laneWidth, 8, bits per lane (one byte)
nrOfLanes, 4, lanes per word; must be a power of two and at least 2
nrOfEntries, 512, words per port (depth of each lane bank)
outputRegister, 0, 0 gives read latency 1; 1 adds an output register stage, giving read latency 2

Ports:
clock  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
requestA  input  1  port A access request this cycle
writeEnableA  input  1  1 = write, 0 = read (qualified by requestA)
byteAddressA  input  $clog2(nrOfEntries*nrOfLanes)  byte address: word = addr/nrOfLanes, offset = addr%nrOfLanes
byteEnableA  input  nrOfLanes  per-byte write mask; bit i qualifies data byte i
dataInA  input  laneWidth*nrOfLanes  write data; byte 0 is the MSB lane
dataOutA  output  laneWidth*nrOfLanes  read data, rotated back to byte order
dataValidA  output  1  dataOutA holds a new read result
requestB  input  1  port B access request
writeEnableB  input  1  1 = write
addressB  input  $clog2(nrOfEntries)  word address
byteEnableB  input  nrOfLanes  per-lane write mask
dataInB  input  laneWidth*nrOfLanes  write data, MSB lane = lane 0
dataOutB  output  laneWidth*nrOfLanes  read data
dataValidB  output  1  dataOutB holds a new read result
collisionB  output  1  one-cycle pulse: a port B lane write was dropped

Behaviour:
- Definitions: L = nrOfLanes; for port A, w = byteAddressA/L and o = byteAddressA%L.
- Port A mapping: data byte i goes to lane (o+i) mod L at entry w if o+i < L, otherwise at entry w+1.
- Entry index w+1 wraps modulo nrOfEntries, so the last entry straddles into entry 0.
- Port A write: lane writes only where requestA & writeEnableA & byteEnableA[i].
- Port B mapping: lane i at addressB, no rotation; lane writes only where requestB & writeEnableB & byteEnableB[i].
- Reads: every lane bank is read every request cycle, read-first. A read in the same cycle as a write to the same lane row (either port) returns the old contents.
- The offset o is registered alongside the read, and the rotation back to byte order uses the registered offset, never the live byteAddressA.
- Latency, outputRegister=0: dataOut and dataValid are valid in cycle N+1 for a read request in cycle N.
- Latency, outputRegister=1: dataOut and dataValid are valid in cycle N+2.
- dataValid pulses once per read request. Writes never raise dataValid.
- dataOut holds its last value while dataValid=0.
- Back-to-back reads are fully pipelined, one per cycle per port.
- Write collision: both ports write the same lane bank at the same entry in the same cycle.
  - Port A wins for that lane; the port B write to that lane is suppressed. Other lanes of the port B write proceed.
  - collisionB = 1 in cycle N+1, for one cycle, independent of outputRegister.
- Reset:
  - dataOutA, dataOutB = 0; dataValidA, dataValidB, collisionB = 0; registered offset = 0; pipeline valids cleared.
  - Any request presented while reset=1 is ignored, writes included.
  - Reads in flight when reset asserts are discarded and never produce dataValid.
  - Memory contents are not reset.
- Both ports are fully independent apart from the collision rule. Port B uses no offset logic.
- Unused inputs (requestX = 0) cause no state change.

Test Plan:
1. Aligned write/read, L=4, laneWidth=8, outputRegister=0: B writes 0x11223344 to word 5 with byteEnableB=1111; A reads byte address 20 -> dataOutA = 0x11223344 and dataValidA = 1 exactly one cycle later.
2. Unaligned write: words 5 and 6 zeroed; A writes 0xAABBCCDD at byte address 22 with byteEnableA=1111 -> B reads word 5 = 0x0000AABB and word 6 = 0xCCDD0000. A read at byte 22 returns 0xAABBCCDD.
3. Wrap and byte mask: A writes 0x01020304 at byte address 2047 (last byte, entry 511) with byteEnableA=1011 -> entry 511 lane 3 = 0x01; entry 0 lane 0 unchanged; entry 0 lane 1 = 0x03; entry 0 lane 2 = 0x04.
4. Pipelined reads with changing offset, outputRegister=1: A reads byte addresses 20, 21, 22 on consecutive cycles -> three correctly rotated words on cycles N+2, N+3, N+4 with dataValidA high for exactly those three cycles.
5. Collision: same cycle, A writes 0xFFFFFFFF at byte 20 and B writes 0x12345678 at word 5 with byteEnableB=0011 -> word 5 = 0xFFFFFFFF and collisionB pulses for one cycle. With byteEnableA=1100 instead -> word 5 = 0xFFFF5678 and collisionB stays 0.
6. Reset mid-read: A read issued, reset asserted the next cycle -> dataValidA stays 0 and dataOutA = 0. A write issued during reset leaves memory unchanged, as confirmed by a read after reset deasserts.
